// File: rtl/dot_matrix_scan.sv
// Row-scan driver for a multiplexed LED dot matrix: double-buffered frame store,
// per-slot anti-ghost blanking, boundary-aligned buffer swap and rotate-left scrolling.
module dot_matrix_scan #(
  parameter int ROWS          = 10,
  parameter int COLS          = 14,
  parameter int SCAN_DIV      = 101,
  parameter int BLANK_CYCLES  = 2,
  parameter int SCROLL_FRAMES = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap_req,
  input  logic                    blank,
  input  logic                    scroll_en,
  output logic [ROWS-1:0]         row_sel,
  output logic [COLS-1:0]         col_data,
  output logic                    frame_start,
  output logic                    swap_done,
  output logic                    wr_err
);

  localparam int RW = $clog2(ROWS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam int OW = $clog2(COLS);

  logic [PW-1:0]   presc_reg;
  logic [RW-1:0]   row_reg;
  logic            front_sel_reg;
  logic            swap_pending_reg;
  logic [OW-1:0]   offset_reg;
  logic [FW-1:0]   frame_cnt_reg;

  // Both buffers must clear on reset, so the frame store lives in flops.
  logic [COLS-1:0] frame_mem [2][ROWS];

  logic            tick;
  logic            frame_end;
  logic            wr_ok;
  logic            wr_bad;
  logic            in_blank;
  logic            do_swap;
  logic [COLS-1:0] front_row;
  logic [2*COLS-1:0] rot_dbl;
  logic [COLS-1:0] rotated;
  logic [ROWS-1:0] row_onehot;

  assign tick      = (presc_reg == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (row_reg == RW'(ROWS - 1));
  assign wr_ok     = wr_en && (int'(wr_row) < ROWS);
  assign wr_bad    = wr_en && !wr_ok;
  assign in_blank  = (int'(presc_reg) < BLANK_CYCLES) || blank;
  assign do_swap   = frame_end && (swap_pending_reg || swap_req);

  assign front_row = frame_mem[front_sel_reg][row_reg];
  // Rotate-left via a doubled word: the upper half after shifting is the rotation.
  assign rot_dbl   = {front_row, front_row} << offset_reg;
  assign rotated   = rot_dbl[2*COLS-1:COLS];

  // Row 0 drives the MSB of row_sel.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_sel
    assign row_onehot[gi] = (row_reg == RW'(ROWS - 1 - gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg        <= '0;
      row_reg          <= '0;
      front_sel_reg    <= 1'b0;
      swap_pending_reg <= 1'b0;
      offset_reg       <= '0;
      frame_cnt_reg    <= '0;
      row_sel          <= '0;
      col_data         <= '0;
      frame_start      <= 1'b0;
      swap_done        <= 1'b0;
      wr_err           <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          frame_mem[b][r] <= '0;
        end
      end
    end else begin
      presc_reg <= tick ? '0 : presc_reg + PW'(1);

      if (tick) begin
        row_reg <= (row_reg == RW'(ROWS - 1)) ? '0 : row_reg + RW'(1);
      end

      // A request arriving in the boundary cycle is absorbed by that same swap.
      if (do_swap) begin
        front_sel_reg    <= ~front_sel_reg;
        swap_pending_reg <= 1'b0;
      end else if (swap_req) begin
        swap_pending_reg <= 1'b1;
      end
      swap_done <= do_swap;

      if (!scroll_en) begin
        offset_reg    <= '0;
        frame_cnt_reg <= '0;
      end else if (frame_end) begin
        if (frame_cnt_reg == FW'(SCROLL_FRAMES - 1)) begin
          frame_cnt_reg <= '0;
          offset_reg    <= (offset_reg == OW'(COLS - 1)) ? '0 : offset_reg + OW'(1);
        end else begin
          frame_cnt_reg <= frame_cnt_reg + FW'(1);
        end
      end

      // Back buffer is chosen from the pre-edge front_sel, so boundary writes hit the new front.
      if (wr_ok) begin
        frame_mem[~front_sel_reg][wr_row] <= wr_data;
      end
      wr_err <= wr_bad;

      frame_start <= (presc_reg == '0) && (row_reg == '0);
      row_sel     <= in_blank ? '0 : row_onehot;
      col_data    <= in_blank ? '0 : rotated;
    end
  end

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Scoreboard bench for dot_matrix_scan: expected per-cycle panel outputs and swap
// events are queued when stimulus is applied and compared as the DUT produces them.
module tb_dot_matrix_scan;

  localparam int ROWS = 10;
  localparam int COLS = 14;
  localparam int SD   = 4;
  localparam int BC   = 1;
  localparam int SF   = 1;
  localparam int FR   = ROWS * SD;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [3:0]      wr_row = '0;
  logic [COLS-1:0] wr_data = '0;
  logic            swap_req = 1'b0;
  logic            blank = 1'b0;
  logic            scroll_en = 1'b0;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_data;
  logic            frame_start;
  logic            swap_done;
  logic            wr_err;

  always #5 clk = ~clk;

  dot_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .SCROLL_FRAMES(SF)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .swap_req(swap_req), .blank(blank), .scroll_en(scroll_en),
    .row_sel(row_sel), .col_data(col_data), .frame_start(frame_start),
    .swap_done(swap_done), .wr_err(wr_err)
  );

  typedef struct packed {
    logic [ROWS-1:0] rs;
    logic [COLS-1:0] cd;
    logic            fs;
    logic            sd;
    logic            we;
  } exp_t;

  exp_t exp_q[$];
  int   swap_q[$];
  int   total = 0;
  int   bad = 0;
  int   phase = 0;

  logic [COLS-1:0] mem_m [2][ROWS];
  int   front_m = 0;
  int   offset_m = 0;
  logic blank_m = 1'b0;

  function automatic logic [COLS-1:0] rotl_m(logic [COLS-1:0] x, int k);
    logic [COLS-1:0] r;
    r = '0;
    for (int i = 0; i < COLS; i++) r[(i + k) % COLS] = x[i];
    return r;
  endfunction

  // Expected outputs for output phase p (cycles since the first post-reset edge).
  function automatic exp_t model(int p);
    exp_t e;
    int pr;
    int rw;
    pr = p % SD;
    rw = (p / SD) % ROWS;
    e = '0;
    e.fs = (pr == 0) && (rw == 0);
    if (pr >= BC && !blank_m) begin
      e.rs = 10'd1 << (ROWS - 1 - rw);
      e.cd = rotl_m(mem_m[front_m][rw], offset_m);
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++) mem_m[b][r] = '0;
    front_m  = 0;
    offset_m = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    phase++;
  endtask

  task automatic align(int m);
    int n;
    n = 0;
    while ((phase % FR) != m && n < 2 * FR) begin
      step();
      n++;
    end
  endtask

  task automatic check_window(int n, string tag);
    exp_t e;
    exp_t got;
    for (int i = 1; i <= n; i++) exp_q.push_back(model(phase + i));
    for (int i = 0; i < n; i++) begin
      step();
      e   = exp_q.pop_front();
      got = exp_t'({row_sel, col_data, frame_start, swap_done, wr_err});
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s phase=%0d got rs=%b cd=%h fs=%b sd=%b we=%b want rs=%b cd=%h fs=%b sd=%b we=%b",
                 tag, phase, got.rs, got.cd, got.fs, got.sd, got.we, e.rs, e.cd, e.fs, e.sd, e.we);
      end
    end
  endtask

  task automatic do_write(int r, logic [COLS-1:0] d);
    wr_en   = 1'b1;
    wr_row  = 4'(r);
    wr_data = d;
    step();
    wr_en = 1'b0;
    if (r < ROWS) mem_m[1 - front_m][r] = d;
  endtask

  task automatic request_swap();
    int q;
    q = phase + 1;
    swap_q.push_back((q / FR) * FR + FR - 1);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic wait_swap(string tag);
    int exp_p;
    int n;
    exp_p = swap_q.pop_front();
    n = 0;
    while (swap_done !== 1'b1 && n < 5 * FR) begin
      step();
      n++;
    end
    total++;
    if (swap_done !== 1'b1 || phase != exp_p) begin
      bad++;
      $display("FAIL %s swap_done=%b at phase=%0d want pulse at phase=%0d", tag, swap_done, phase, exp_p);
    end
    front_m = 1 - front_m;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({row_sel, col_data, frame_start, swap_done, wr_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got rs=%b cd=%h fs=%b sd=%b we=%b want all 0",
               row_sel, col_data, frame_start, swap_done, wr_err);
    end
    model_reset();
    rst   = 1'b0;
    phase = -1;
  endtask

  task automatic test_write_swap();
    do_write(3, 14'h2AAA);
    total++;
    if (frame_start !== 1'b1) begin
      bad++;
      $display("FAIL first_frame_start got %b want 1", frame_start);
    end
    request_swap();
    wait_swap("swap_first");
    check_window(2 * FR, "scan_after_swap");
  endtask

  task automatic test_blank();
    blank   = 1'b1;
    blank_m = 1'b1;
    check_window(FR + 5, "blank_hold");
    blank   = 1'b0;
    blank_m = 1'b0;
    check_window(FR, "blank_release");
  endtask

  task automatic test_back_to_back();
    do_write(0, 14'h3FFF);
    check_window(FR, "backbuf_write_hidden");
    align(5);
    request_swap();
    step();
    step();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    wait_swap("swap_double_req");
    check_window(2 * FR, "after_double_req");
  endtask

  task automatic test_scroll();
    do_write(0, 14'h2000);
    request_swap();
    wait_swap("swap_scroll");
    align(0);
    scroll_en = 1'b1;
    offset_m  = 0;
    check_window(FR - 1, "scroll_off0");
    offset_m = 1;
    check_window(FR, "scroll_off1");
    offset_m = 2;
    check_window(FR, "scroll_off2");
    scroll_en = 1'b0;
    offset_m  = 0;
    check_window(FR, "scroll_drop");
  endtask

  task automatic test_wr_err();
    wr_en   = 1'b1;
    wr_row  = 4'd12;
    wr_data = 14'h3FFF;
    step();
    wr_en = 1'b0;
    total++;
    if (wr_err !== 1'b1) begin
      bad++;
      $display("FAIL wr_err_pulse got %b want 1", wr_err);
    end
    step();
    total++;
    if (wr_err !== 1'b0) begin
      bad++;
      $display("FAIL wr_err_clear got %b want 0", wr_err);
    end
    request_swap();
    wait_swap("swap_after_bad_write");
    check_window(FR, "no_write_on_err");
  endtask

  task automatic test_reset_midframe();
    align(24);
    request_swap();
    swap_q.delete();
    step();
    rst = 1'b1;
    step();
    total++;
    if ({row_sel, col_data, frame_start, swap_done, wr_err} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got rs=%b cd=%h fs=%b sd=%b we=%b want all 0",
               row_sel, col_data, frame_start, swap_done, wr_err);
    end
    step();
    rst = 1'b0;
    model_reset();
    phase = -1;
    check_window(2 * FR, "after_midreset");
    request_swap();
    wait_swap("swap_after_midreset");
    check_window(FR, "other_buf_cleared");
  endtask

  initial begin
    test_reset();
    test_write_swap();
    test_blank();
    test_back_to_back();
    test_scroll();
    test_wr_err();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_matrix_scan.md
Name: dot_matrix_scan

Overview:
Parametrised row-scan driver for a multiplexed LED dot matrix. Holds a double-buffered frame memory that the host writes one row at a time. Scans the front buffer one row per slot with anti-ghost blanking. Supports glitch-free frame swap at frame boundaries and optional horizontal rotate-scroll. Sits between game/score logic and the panel's row/column pins.

Parameters:
ROWS, 10, number of panel rows (>=2)
COLS, 14, number of panel columns (>=2)
SCAN_DIV, 101, clk cycles per row slot (>= BLANK_CYCLES+1)
BLANK_CYCLES, 2, cycles at the start of each row slot with outputs forced off
SCROLL_FRAMES, 25, complete frames per 1-column scroll step (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write wr_data into back-buffer row wr_row
wr_row  in  $clog2(ROWS)  back-buffer row address, 0 = top
wr_data  in  COLS  row pixels, MSB = leftmost column
swap_req  in  1  request front/back exchange at next frame boundary
blank  in  1  force panel dark; scanning continues
scroll_en  in  1  enable rotate-left scrolling of displayed image
row_sel  out  ROWS  one-hot row drive, MSB = row 0
col_data  out  COLS  column drive for the active row
frame_start  out  1  1-cycle pulse in the first cycle of row 0's slot
swap_done  out  1  1-cycle pulse in the cycle the swap takes effect
wr_err  out  1  1-cycle pulse when wr_en is asserted with wr_row >= ROWS

Behaviour:
- Reset (rst=1 at a clock edge): prescaler=0, row=0, front_sel=0, swap_pending=0, scroll offset=0, frame counter=0, both buffers cleared to all zeros. All outputs 0. A reset mid-frame or mid-swap restarts at row 0, slot cycle 0.
- Prescaler counts 0..SCAN_DIV-1 and wraps. "tick" = prescaler==SCAN_DIV-1.
- Row index advances on tick, wrapping ROWS-1 -> 0. "frame boundary" = tick with row==ROWS-1.
- Outputs are registered and reflect the prescaler/row state with 1-cycle latency.
- In slot cycles 0..BLANK_CYCLES-1, or whenever blank=1: row_sel=0 and col_data=0.
- In all other slot cycles: row_sel has only bit (ROWS-1-row) set, and col_data = rotl(front[row], offset).
- frame_start: asserted in the registered cycle that corresponds to row 0, slot cycle 0. This pulse occurs even when blank=1.
- Write path:
  - When wr_en=1 and wr_row<ROWS, the back buffer (buffer !front_sel, as sampled in that same cycle) row wr_row takes wr_data at the edge.
  - When wr_row>=ROWS, no write occurs and wr_err pulses on the next cycle.
  - The front buffer is never writable.
- Swap:
  - swap_req=1 sets swap_pending. Repeated requests while pending have no additional effect.
  - At a frame boundary, if (swap_pending | swap_req), front_sel toggles, swap_pending clears, and swap_done pulses the next cycle. A swap_req in the boundary cycle is consumed by that swap.
  - A write in the boundary cycle lands in the pre-swap back buffer, i.e. the new front buffer.
  - Buffer contents are not copied on swap.
- Scroll:
  - The frame counter increments at each frame boundary while scroll_en=1.
  - When the counter reaches SCROLL_FRAMES-1, it wraps to 0 and offset increments modulo COLS.
  - scroll_en=0 clears offset and the frame counter to 0 on the next edge.
  - Offset changes only at frame boundaries, so there is no mid-frame tearing.
- rotl(x,k): rotate left by k columns. Column MSB data moves off the left edge and re-enters at the LSB.
- Arithmetic: all counters are unsigned with explicit wrap compares; no reliance on natural overflow for non-power-of-2 ROWS/COLS/SCAN_DIV.

Test Plan:
- ROWS=10, COLS=14, SCAN_DIV=4, BLANK_CYCLES=1. Reset, then write row 3 = 14'h2AAA, then swap_req.
  -> swap_done pulses after the first frame boundary (40 clocks).
  -> During row 3's slot: row_sel=10'b0001000000 and col_data=14'h2AAA for cycles 1..3; both 0 in cycle 0.
  -> frame_start period = 40 clocks.
- Hold blank=1 for a full frame.
  -> row_sel and col_data stay 0.
  -> frame_start still pulses every 40 clocks.
  -> Releasing blank restores the image at the next non-blank slot cycle.
- Write back-buffer row 0 = 14'h3FFF while displaying, without swap.
  -> Displayed row 0 is unchanged.
  -> Assert swap_req twice in one frame: exactly one swap_done occurs, and the new front row 0 = 14'h3FFF.
- SCROLL_FRAMES=1, front row 0 = 14'h2000, scroll_en=1.
  -> Row 0 col_data = 14'h2000, then 14'h0001, then 14'h0002 on successive frames.
  -> Drop scroll_en: next frame shows 14'h2000.
- wr_en=1, wr_row=12.
  -> wr_err=1 for one cycle; no buffer changes.
- Assert rst mid-frame (row 6) with swap pending.
  -> All outputs 0 next cycle, buffers zero, no swap_done.
  -> Scanning resumes at row 0; the first frame_start occurs on the cycle after rst is deasserted.
